// File: rtl/seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_generator
//  Purpose  : Serial pattern generator. On start it sends up to MAXLEN bits
//             of a latched pattern, MSB-first (bit len-1 down to bit 0). The
//             pattern is repeated reps extra times, with gap idle cycles
//             between repetitions, and a one-cycle done pulse at the end.
//             All outputs are registered.
//  Ports    : clk      - clock, rising edge active
//             reset    - asynchronous active-high reset
//             start    - transmit request, sampled only in IDLE
//             pattern  - bits to send (bit len-1 goes out first)
//             len      - number of bits to send (clamped to MAXLEN)
//             reps     - extra repetitions (0 = send once)
//             gap      - idle cycles between repetitions
//             abort    - synchronous stop of an active transmission
//             x        - serial bit
//             x_valid  - x carries a pattern bit this cycle
//             busy     - transmission in progress (SEND or GAP)
//             done     - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module seq_generator #(
    parameter int MAXLEN = 16,
    parameter int CNTW   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MAXLEN-1:0]         pattern,
    input  logic [$clog2(MAXLEN):0]   len,
    input  logic [CNTW-1:0]           reps,
    input  logic [CNTW-1:0]           gap,
    input  logic                      abort,
    output logic                      x,
    output logic                      x_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int c_LEN_W = $clog2(MAXLEN) + 1;
    localparam int c_IDX_W = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAXLEN);
    localparam logic [c_LEN_W-1:0] c_LEN_ONE = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0] c_LEN_ZERO = '0;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO = '0;
    localparam logic [CNTW-1:0]    c_CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0]    c_CNT_ZERO = '0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    // State and latched transmission fields
    logic [1:0]          r_state;
    logic [MAXLEN-1:0]   r_pattern;
    logic [c_IDX_W-1:0]  r_first_idx;   // index of the first bit of each repetition
    logic [CNTW-1:0]     r_gap;
    logic [c_IDX_W-1:0]  r_bit_idx;     // index of the bit currently on x
    logic [CNTW-1:0]     r_rep_cnt;     // repetitions still to send after this one
    logic [CNTW-1:0]     r_gap_cnt;     // gap cycles left including the current one
    logic                r_x;
    logic                r_x_valid;
    logic                r_busy;
    logic                r_done;

    // Next-state values
    logic [1:0]          w_state_nx;
    logic [MAXLEN-1:0]   w_pattern_nx;
    logic [c_IDX_W-1:0]  w_first_idx_nx;
    logic [CNTW-1:0]     w_gap_nx;
    logic [c_IDX_W-1:0]  w_bit_idx_nx;
    logic [CNTW-1:0]     w_rep_cnt_nx;
    logic [CNTW-1:0]     w_gap_cnt_nx;
    logic                w_x_nx;
    logic                w_x_valid_nx;
    logic                w_busy_nx;
    logic                w_done_nx;

    // Length clamped to MAXLEN and the resulting first-bit index
    logic [c_LEN_W-1:0]  w_len_eff;
    logic [c_IDX_W-1:0]  w_in_first_idx;
    logic [c_IDX_W-1:0]  w_idx_dec;

    assign w_len_eff      = (len > c_MAX_LEN) ? c_MAX_LEN : len;
    assign w_in_first_idx = c_IDX_W'(w_len_eff - c_LEN_ONE);
    assign w_idx_dec      = r_bit_idx - c_IDX_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_pattern   <= '0;
            r_first_idx <= '0;
            r_gap       <= '0;
            r_bit_idx   <= '0;
            r_rep_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pattern   <= w_pattern_nx;
            r_first_idx <= w_first_idx_nx;
            r_gap       <= w_gap_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_rep_cnt   <= w_rep_cnt_nx;
            r_gap_cnt   <= w_gap_cnt_nx;
            r_x         <= w_x_nx;
            r_x_valid   <= w_x_valid_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
        end
    end

    always_comb begin
        // Hold latched fields; outputs fall to their idle values unless driven
        w_state_nx     = r_state;
        w_pattern_nx   = r_pattern;
        w_first_idx_nx = r_first_idx;
        w_gap_nx       = r_gap;
        w_bit_idx_nx   = r_bit_idx;
        w_rep_cnt_nx   = r_rep_cnt;
        w_gap_cnt_nx   = r_gap_cnt;
        w_x_nx         = 1'b0;
        w_x_valid_nx   = 1'b0;
        w_busy_nx      = 1'b0;
        w_done_nx      = 1'b0;

        case (r_state)
            c_IDLE: begin
                // abort has priority over start, even while idle
                if (start && !abort) begin
                    w_pattern_nx   = pattern;
                    w_first_idx_nx = w_in_first_idx;
                    w_gap_nx       = gap;
                    w_rep_cnt_nx   = reps;
                    if (w_len_eff == c_LEN_ZERO) begin
                        // Nothing to send: report completion straight away
                        w_done_nx = 1'b1;
                    end else begin
                        w_state_nx   = c_SEND;
                        w_bit_idx_nx = w_in_first_idx;
                        w_x_nx       = pattern[w_in_first_idx];
                        w_x_valid_nx = 1'b1;
                        w_busy_nx    = 1'b1;
                    end
                end
            end

            c_SEND: begin
                if (abort) begin
                    w_state_nx = c_IDLE;
                end else if (r_bit_idx != c_IDX_ZERO) begin
                    w_bit_idx_nx = w_idx_dec;
                    w_x_nx       = r_pattern[w_idx_dec];
                    w_x_valid_nx = 1'b1;
                    w_busy_nx    = 1'b1;
                end else if (r_rep_cnt != c_CNT_ZERO) begin
                    w_rep_cnt_nx = r_rep_cnt - c_CNT_ONE;
                    w_busy_nx    = 1'b1;
                    if (r_gap != c_CNT_ZERO) begin
                        w_state_nx   = c_GAP;
                        w_gap_cnt_nx = r_gap;
                    end else begin
                        // Zero gap: next repetition starts without a bubble
                        w_bit_idx_nx = r_first_idx;
                        w_x_nx       = r_pattern[r_first_idx];
                        w_x_valid_nx = 1'b1;
                    end
                end else begin
                    w_state_nx = c_IDLE;
                    w_done_nx  = 1'b1;
                end
            end

            c_GAP: begin
                if (abort) begin
                    w_state_nx = c_IDLE;
                end else begin
                    w_busy_nx = 1'b1;
                    if (r_gap_cnt <= c_CNT_ONE) begin
                        w_state_nx   = c_SEND;
                        w_gap_cnt_nx = c_CNT_ZERO;
                        w_bit_idx_nx = r_first_idx;
                        w_x_nx       = r_pattern[r_first_idx];
                        w_x_valid_nx = 1'b1;
                    end else begin
                        w_gap_cnt_nx = r_gap_cnt - c_CNT_ONE;
                    end
                end
            end

            default: begin
                w_state_nx = c_IDLE;
            end
        endcase
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_generator
//  Purpose  : Self-checking bench for seq_generator. A reference model turns
//             (pattern, len, reps, gap) into the cycle-by-cycle list of
//             {x, x_valid, busy, done} expected after the start edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_generator;

    logic        clk = 1'b1;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic [3:0]  gap;
    logic        abort;
    logic        x;
    logic        x_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];   // {x, x_valid, busy, done} per cycle after start

    always #5 clk = ~clk;

    seq_generator #(.MAXLEN(16), .CNTW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .abort   (abort),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    // Expected output stream for one transmission
    task automatic build_model(input logic [15:0] p, input int l, input int r, input int g);
        int eff;
        exp_q.delete();
        eff = (l > 16) ? 16 : l;
        if (eff == 0) begin
            exp_q.push_back(4'b0001);
            return;
        end
        for (int k = 0; k <= r; k++) begin
            for (int b = eff - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
            if (k < r) for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    // Called at a falling edge: requests a transmission at the next rising edge
    task automatic launch(input logic [15:0] p, input int l, input int r, input int g);
        pattern = p;
        len     = 5'(l);
        reps    = 4'(r);
        gap     = 4'(g);
        abort   = 1'b0;
        start   = 1'b1;
        build_model(p, l, r, g);
    endtask

    // Follows the model stream; while busy the inputs are scrambled and start
    // is toggled at random, none of which may disturb the transmission.
    task automatic follow(input string name, input bit chain, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({x, x_valid, busy, done} !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: {x,x_valid,busy,done} got %b expected %b",
                         name, i, {x, x_valid, busy, done}, exp_q[i]);
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (exp_q[i][1]) begin
                start   = 1'($urandom_range(0, 1));
                pattern = 16'($urandom);
                len     = 5'($urandom);
                reps    = 4'($urandom);
                gap     = 4'($urandom);
            end else if (!(exp_q[i][0] && chain)) begin
                start = 1'b0;
            end
        end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if ({x, x_valid, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL %s idle-after-done: got %b expected 0000", name, {x, x_valid, busy, done});
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: {x,x_valid,busy,done} got %b expected 0000", name, {x, x_valid, busy, done});
        end
    endtask

    task automatic check_counts(input string name, input int bn, input int dn, input int eb, input int ed);
        checks++;
        if (bn !== eb || dn !== ed) begin
            errors++;
            $display("FAIL %s: busy cycles %0d done pulses %0d, expected %0d and %0d", name, bn, dn, eb, ed);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; reps = '0; gap = '0;
        @(negedge clk);                 // t=5, in reset
        check_idle("reset_held");
        @(negedge clk);                 // t=15, release after 15 ns
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("reset_idle");
        end
    endtask

    task automatic test_basic();
        int bn, dn;
        launch(16'b0011_0110, 8, 0, 0);
        follow("basic8", 1'b0, bn, dn);
        check_counts("basic8_counts", bn, dn, 8, 1);
    endtask

    task automatic test_repeat_gap();
        int bn, dn;
        launch(16'b1011, 4, 2, 3);
        follow("rep_gap", 1'b0, bn, dn);
        check_counts("rep_gap_counts", bn, dn, 18, 1);
    endtask

    task automatic test_back_to_back();
        int bn, dn;
        launch(16'($urandom), 4, 1, 0);
        follow("b2b_first", 1'b1, bn, dn);
        check_counts("b2b_first_counts", bn, dn, 8, 1);
        launch(16'($urandom), 5, 0, 0);  // start in the done cycle
        follow("b2b_second", 1'b0, bn, dn);
        check_counts("b2b_second_counts", bn, dn, 5, 1);
    endtask

    task automatic test_abort();
        launch(16'($urandom), 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({x, x_valid, busy, done} !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_bit%0d: got %b expected %b", i, {x, x_valid, busy, done}, exp_q[i]);
            end
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_idle("abort_stop");
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("abort_no_done");
        // abort together with start while idle: start is ignored
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_idle("abort_start_idle");
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("abort_start_idle2");
    endtask

    task automatic test_len_edges();
        int bn, dn;
        launch(16'($urandom), 0, 2, 1);
        follow("len0", 1'b0, bn, dn);
        check_counts("len0_counts", bn, dn, 0, 1);
        launch(16'($urandom), 20, 0, 0);
        follow("len20", 1'b0, bn, dn);
        check_counts("len20_counts", bn, dn, 16, 1);
        launch(16'($urandom), 1, 15, 0);
        follow("reps_max", 1'b0, bn, dn);
        check_counts("reps_max_counts", bn, dn, 16, 1);
    endtask

    task automatic test_async_reset();
        int bn, dn;
        launch(16'b10, 2, 1, 5);
        for (int i = 0; i < 4; i++) begin   // two bits then two gap cycles
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({x, x_valid, busy, done} !== exp_q[i]) begin
                errors++;
                $display("FAIL gap_pre_reset%0d: got %b expected %b", i, {x, x_valid, busy, done}, exp_q[i]);
            end
        end
        #2 reset = 1'b1;
        #1 check_idle("async_reset_immediate");
        @(negedge clk);
        check_idle("async_reset_held");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("async_reset_no_done");
        end
        launch(16'($urandom), 6, 1, 2);
        follow("after_reset", 1'b0, bn, dn);
        check_counts("after_reset_counts", bn, dn, 14, 1);
    endtask

    task automatic test_random();
        int bn, dn;
        bit chain;
        for (int n = 0; n < 25; n++) begin
            chain = (n != 24) && ($urandom_range(0, 2) == 0);
            launch(16'($urandom), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            follow("random", chain, bn, dn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat_gap();
        test_back_to_back();
        test_abort();
        test_len_edges();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
